// File: rtl/clock_logic_pkg.sv
// clock_logic_pkg: shared FSM state encoding for the clock_logic block family
package clock_logic_pkg;
  typedef enum logic [1:0] {IDLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW} deglitch_state_t;
endpackage

// File: rtl/clock_logic_sat_counter.sv
// clock_logic_sat_counter: saturating up-counter with sync clear; clear+inc together yields 1
module clock_logic_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else if (clear) count <= inc ? CNT_W'(1) : '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/clock_logic_sync_deglitch.sv
// clock_logic_sync_deglitch: level qualifier with edge pulses and glitch flag; CLOCK_LOGIC_DEGLITCH_EDGE_COUNT_EN enables edge_count
module clock_logic_sync_deglitch
  import clock_logic_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int RESET_LEVEL   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             level_in,
  input  logic             count_clear,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             glitch,
  output logic [CNT_W-1:0] edge_count
);
  if (STABLE_CYCLES < 1 || STABLE_CYCLES >= 2**CNT_W) begin : g_bad_param
    $fatal(1, "STABLE_CYCLES out of range");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit ONE = STABLE_CYCLES == 1;
  deglitch_state_t state;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock) begin
    rise_pulse <= 1'b0;
    fall_pulse <= 1'b0;
    glitch     <= 1'b0;
    if (reset) begin
      state     <= (RESET_LEVEL != 0) ? STABLE_HIGH : IDLE_LOW;
      level_out <= (RESET_LEVEL != 0);
      cnt       <= '0;
    end else begin
      case (state)
        IDLE_LOW:
          if (level_in) begin
            if (ONE) begin
              state      <= STABLE_HIGH;
              level_out  <= 1'b1;
              rise_pulse <= 1'b1;
            end else begin
              state <= QUAL_HIGH;
              cnt   <= CNT_W'(1);
            end
          end
        QUAL_HIGH:
          if (!level_in) begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            glitch <= 1'b1;
          end else if (cnt == LAST) begin
            state      <= STABLE_HIGH;
            cnt        <= '0;
            level_out  <= 1'b1;
            rise_pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
        STABLE_HIGH:
          if (!level_in) begin
            if (ONE) begin
              state      <= IDLE_LOW;
              level_out  <= 1'b0;
              fall_pulse <= 1'b1;
            end else begin
              state <= QUAL_LOW;
              cnt   <= CNT_W'(1);
            end
          end
        QUAL_LOW:
          if (level_in) begin
            state  <= STABLE_HIGH;
            cnt    <= '0;
            glitch <= 1'b1;
          end else if (cnt == LAST) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            level_out  <= 1'b0;
            fall_pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
      endcase
    end
  end
`ifdef CLOCK_LOGIC_DEGLITCH_EDGE_COUNT_EN
  clock_logic_sat_counter #(.CNT_W(CNT_W)) u_edge_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (rise_pulse),
    .clear (count_clear),
    .count (edge_count)
  );
`else
  logic unused_count_clear;
  assign unused_count_clear = count_clear;
  assign edge_count = '0;
`endif
endmodule

// File: tb/tb_clock_logic_sync_deglitch.sv
// tb_clock_logic_sync_deglitch: vector table, corner sequences and randomized run against a run-length model
module tb_clock_logic_sync_deglitch;
  localparam int S = 4;
  localparam int W = 8;
  localparam int MAXC = (1 << W) - 1;
  logic clock = 1'b0;
  logic reset, level_in, count_clear;
  logic level_out, rise_pulse, fall_pulse, glitch;
  logic [W-1:0] edge_count;
  int checks = 0, errors = 0;
  int m_lvl = 0, m_run = 0, m_ec = 0;
  bit m_rise = 0, m_fall = 0, m_gl = 0;
  typedef struct {
    bit r, l, c;
    bit lo, ri, fa, gl;
  } vec_t;
  vec_t tv[$];

  clock_logic_sync_deglitch #(.STABLE_CYCLES(S), .CNT_W(W), .RESET_LEVEL(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .level_in    (level_in),
    .count_clear (count_clear),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .glitch      (glitch),
    .edge_count  (edge_count)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: count consecutive samples differing from the accepted level; S in a row flips it
  task automatic step(bit r, bit l, bit c);
    reset = r;
    level_in = l;
    count_clear = c;
    @(posedge clock);
    if (r) begin
      m_lvl = 0; m_run = 0; m_ec = 0;
      m_rise = 0; m_fall = 0; m_gl = 0;
    end else begin
`ifdef CLOCK_LOGIC_DEGLITCH_EDGE_COUNT_EN
      if (c) m_ec = m_rise ? 1 : 0;
      else if (m_rise && m_ec < MAXC) m_ec = m_ec + 1;
`else
      m_ec = 0;
`endif
      m_rise = 0; m_fall = 0; m_gl = 0;
      if (int'(l) != m_lvl) begin
        m_run = m_run + 1;
        if (m_run == S) begin
          m_lvl = int'(l);
          m_run = 0;
          m_rise = l;
          m_fall = !l;
        end
      end else begin
        m_gl = m_run > 0;
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic check_model();
    chk("level_out", 32'(level_out), 32'(m_lvl));
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    chk("glitch", 32'(glitch), 32'(m_gl));
    chk("edge_count", 32'(edge_count), 32'(m_ec));
    chk("rise_fall_excl", 32'(rise_pulse & fall_pulse), 0);
  endtask

  initial begin
    reset = 1'b1; level_in = 1'b0; count_clear = 1'b0;
    for (int i = 0; i < 3; i++) tv.push_back('{1, 0, 0, 0, 0, 0, 0});
    for (int i = 1; i <= 10; i++) tv.push_back('{0, 1, 0, i >= 4, i == 4, 0, 0});
    for (int i = 1; i <= 5; i++) tv.push_back('{0, 0, 0, i < 4, 0, i == 4, 0});
    for (int i = 0; i < 3; i++) tv.push_back('{0, 1, 0, 0, 0, 0, 0});
    tv.push_back('{0, 0, 0, 0, 0, 0, 1});
    tv.push_back('{0, 0, 0, 0, 0, 0, 0});
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].l, tv[i].c);
      chk($sformatf("vec%0d_level", i), 32'(level_out), 32'(tv[i].lo));
      chk($sformatf("vec%0d_rise", i), 32'(rise_pulse), 32'(tv[i].ri));
      chk($sformatf("vec%0d_fall", i), 32'(fall_pulse), 32'(tv[i].fa));
      chk($sformatf("vec%0d_glitch", i), 32'(glitch), 32'(tv[i].gl));
      chk($sformatf("vec%0d_edge_count", i), 32'(edge_count), 32'(m_ec));
    end
    for (int i = 0; i < 20; i++) begin
      step(0, (i % 2) == 0, 0);
      chk("toggle_level", 32'(level_out), 0);
      chk("toggle_glitch", 32'(glitch), 32'((i % 2) == 1));
      check_model();
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("stable_high", 32'(level_out), 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("rst_mid_level", 32'(level_out), 0);
    chk("rst_mid_fall", 32'(fall_pulse), 0);
    step(0, 0, 0);
    chk("rst_after_fall", 32'(fall_pulse), 0);
    check_model();
`ifdef CLOCK_LOGIC_DEGLITCH_EDGE_COUNT_EN
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
    end
    chk("edge_count_sat", 32'(edge_count), 255);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("rise_before_clear", 32'(rise_pulse), 1);
    step(0, 1, 1);
    chk("clear_with_rise", 32'(edge_count), 1);
    check_model();
`else
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) step(0, 1, n == 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      chk("edge_count_off", 32'(edge_count), 0);
    end
`endif
    for (int n = 0; n < 600; n++) begin
      automatic bit lv = 1'($urandom_range(0, 1));
      automatic int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        step($urandom_range(0, 199) == 0, lv, $urandom_range(0, 15) == 0);
        check_model();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
